// File: rtl/pred_ctx_pkg.sv
// Shared definitions for the predicate-path context sequencer: context word
// layout, NOP constants and FSM state encoding.
package pred_ctx_pkg;

  localparam int CTX_W = 47;

  // Field widths of the context word
  localparam int IN_SEL_W  = 9;
  localparam int PUT_W     = 6;
  localparam int PRED_W    = 6;
  localparam int SEND_W    = 6;
  localparam int OUT_SEL_W = 9;
  localparam int PE2FU_W   = 4;

  // Bit offsets (LSB position) of each field inside the 47-bit word
  localparam int PE2FU_OFS   = 0;
  localparam int OUT_SEL_OFS = 4;
  localparam int SEND_OFS    = 13;
  localparam int PRED_OFS    = 19;
  localparam int WB_OFS      = 25;
  localparam int PUT_OUT_OFS = 26;
  localparam int PUT_IN_OFS  = 32;
  localparam int IN_SEL_OFS  = 38;

  // Packed layout, MSB first; field order matches the offsets above
  typedef struct packed {
    logic [IN_SEL_W-1:0]  in_sel;
    logic [PUT_W-1:0]     put_in;
    logic [PUT_W-1:0]     put_out;
    logic                 wb;
    logic [PRED_W-1:0]    pred_rd;
    logic [SEND_W-1:0]    send;
    logic [OUT_SEL_W-1:0] out_sel;
    logic [PE2FU_W-1:0]   pe2fu;
  } ctx_word_t;

  // Register 63 absorbs the put_in write the register file performs every cycle
  localparam logic [PUT_W-1:0]   SINK_ADDR = 6'd63;
  localparam logic [PE2FU_W-1:0] PE2FU_NOP = 4'b1111;

  localparam ctx_word_t NOP_WORD = '{
    in_sel:  '0,
    put_in:  SINK_ADDR,
    put_out: SINK_ADDR,
    wb:      1'b0,
    pred_rd: '0,
    send:    '0,
    out_sel: '0,
    pe2fu:   PE2FU_NOP
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pred_ctx_seq_if.sv
// Configuration, control and predicate-crossbar control bundle of the
// context sequencer. master = loader/test side, slave = sequencer.
interface pred_ctx_seq_if #(
  parameter int CTX_AW = 4
);
  logic                         cfg_we;
  logic [CTX_AW-1:0]            cfg_addr;
  logic [pred_ctx_pkg::CTX_W-1:0] cfg_data;
  logic                         start;
  logic                         abort;
  logic                         stall;
  logic [CTX_AW-1:0]            last_pc;
  logic [7:0]                   loop_cnt;

  logic [8:0]                   control_in_p;
  logic [5:0]                   control_put_in_p;
  logic [5:0]                   control_put_out_p;
  logic                         write_back_p;
  logic [5:0]                   control_pred;
  logic [5:0]                   control_send_p;
  logic [8:0]                   control_out_p;
  logic [3:0]                   control_pe2fu_p;
  logic                         busy;
  logic                         done;
  logic [CTX_AW-1:0]            ctx_pc;
  logic                         conflict_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, abort, stall, last_pc, loop_cnt,
    input  control_in_p, control_put_in_p, control_put_out_p, write_back_p,
           control_pred, control_send_p, control_out_p, control_pe2fu_p,
           busy, done, ctx_pc, conflict_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, abort, stall, last_pc, loop_cnt,
    output control_in_p, control_put_in_p, control_put_out_p, write_back_p,
           control_pred, control_send_p, control_out_p, control_pe2fu_p,
           busy, done, ctx_pc, conflict_err
  );
endinterface

// File: rtl/pred_ctx_mem.sv
// Context memory: CTX_DEPTH x 47 register array, synchronous write,
// asynchronous read. Contents are not reset.
module pred_ctx_mem
  import pred_ctx_pkg::*;
#(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [CTX_AW-1:0] waddr,
  input  ctx_word_t         wdata,
  input  logic [CTX_AW-1:0] raddr,
  output ctx_word_t         rdata
);

  ctx_word_t mem [CTX_DEPTH];

  // Write port; the caller gates we so that only IDLE writes land
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pred_ctx_seq.sv
// Predicate-path context sequencer for one PE. Steps through the context
// memory on start and drives the predicate register file / crossbar controls
// from registered outputs (NOP whenever nothing is issued).
// Optional feature macro: PRED_CTX_WBCHK_EN enables the write-back conflict
// checker; when undefined, conflict_err is tied low.
module pred_ctx_seq
  import pred_ctx_pkg::*;
#(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input logic          CLK,
  input logic          RST,
  pred_ctx_seq_if.slave bus
);

  state_t            state;
  ctx_word_t         rd_word;
  ctx_word_t         out_word;
  logic [CTX_AW-1:0] rd_addr;
  logic              mem_we;

  // pc/iter name the next context to be issued; fin marks that the word on
  // the outputs is the final one of the final iteration
  logic [CTX_AW-1:0] pc;
  logic [7:0]        iter;
  logic              fin;
  logic [CTX_AW-1:0] lpc;
  logic [7:0]        imax;
  logic              busy_r;
  logic              done_r;
  logic [CTX_AW-1:0] ctx_pc_r;

  logic              at_end;
  logic              is_final;
  logic              start_acc;

  assign mem_we    = bus.cfg_we && (state == ST_IDLE);
  assign rd_addr   = (state == ST_RUN) ? pc : '0;
  assign at_end    = (pc == lpc);
  assign is_final  = at_end && (iter == imax);
  assign start_acc = (state == ST_IDLE) && bus.start && !bus.abort;

  pred_ctx_mem #(
    .CTX_DEPTH (CTX_DEPTH),
    .CTX_AW    (CTX_AW)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (bus.cfg_addr),
    .wdata (ctx_word_t'(bus.cfg_data)),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // FSM, PC/iteration sequencing and registered control outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      out_word <= NOP_WORD;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ctx_pc_r <= '0;
      pc       <= '0;
      iter     <= '0;
      fin      <= 1'b0;
      lpc      <= '0;
      imax     <= '0;
    end else if (bus.abort) begin
      state    <= ST_IDLE;
      out_word <= NOP_WORD;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      fin      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_word <= NOP_WORD;
          done_r   <= 1'b0;
          if (bus.start) begin
            // Context 0 is issued straight away; pc/iter then point past it
            state    <= ST_RUN;
            busy_r   <= 1'b1;
            out_word <= rd_word;
            ctx_pc_r <= '0;
            lpc      <= bus.last_pc;
            imax     <= (bus.loop_cnt == 8'd0) ? 8'd0 : bus.loop_cnt - 8'd1;
            fin      <= (bus.last_pc == '0) && (bus.loop_cnt <= 8'd1);
            pc       <= (bus.last_pc == '0) ? '0 : CTX_AW'(1);
            iter     <= (bus.last_pc == '0) ? 8'd1 : 8'd0;
          end
        end
        ST_RUN: begin
          if (bus.stall) begin
            out_word <= NOP_WORD;
          end else if (fin) begin
            state    <= ST_DONE;
            out_word <= NOP_WORD;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            fin      <= 1'b0;
          end else begin
            out_word <= rd_word;
            ctx_pc_r <= pc;
            fin      <= is_final;
            if (at_end) begin
              pc   <= '0;
              iter <= iter + 8'd1;
            end else begin
              pc   <= pc + CTX_AW'(1);
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          out_word <= NOP_WORD;
          done_r   <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          out_word <= NOP_WORD;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRED_CTX_WBCHK_EN
  logic conflict_r;

  // Sticky flag for a word that writes back onto its own put_in register
  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_r <= 1'b0;
    end else if (start_acc) begin
      conflict_r <= 1'b0;
    end else if (out_word.wb && (out_word.put_out == out_word.put_in) &&
                 (out_word.put_in != SINK_ADDR)) begin
      conflict_r <= 1'b1;
    end
  end

  assign bus.conflict_err = conflict_r;
`else
  assign bus.conflict_err = 1'b0;
`endif

  assign bus.control_in_p      = out_word.in_sel;
  assign bus.control_put_in_p  = out_word.put_in;
  assign bus.control_put_out_p = out_word.put_out;
  assign bus.write_back_p      = out_word.wb;
  assign bus.control_pred      = out_word.pred_rd;
  assign bus.control_send_p    = out_word.send;
  assign bus.control_out_p     = out_word.out_sel;
  assign bus.control_pe2fu_p   = out_word.pe2fu;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.ctx_pc            = ctx_pc_r;

endmodule

// File: tb/tb_pred_ctx_seq.sv
// Directed bench for pred_ctx_seq: reset, basic loop, stall, abort,
// write-while-running, loop_cnt=0 and the write-back conflict flag.
module tb_pred_ctx_seq;

`ifdef PRED_CTX_WBCHK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pred_ctx_seq_if #(.CTX_AW(4)) bus ();

  pred_ctx_seq #(
    .CTX_DEPTH (16),
    .CTX_AW    (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Hand-built words: {in_sel, put_in, put_out, wb, pred_rd, send, out_sel, pe2fu}
  logic [46:0] nop_w = {9'd0,   6'd63, 6'd63, 1'b0, 6'd0,  6'd0,  9'd0,   4'b1111};
  logic [46:0] c0    = {9'h101, 6'd1,  6'd2,  1'b1, 6'd3,  6'd4,  9'h0a5, 4'h1};
  logic [46:0] c1    = {9'h0f0, 6'd7,  6'd8,  1'b0, 6'd9,  6'd10, 9'h1ff, 4'h2};
  logic [46:0] c2    = {9'h033, 6'd11, 6'd12, 1'b1, 6'd13, 6'd14, 9'h100, 4'h4};
  logic [46:0] c3    = {9'h001, 6'd5,  6'd5,  1'b1, 6'd0,  6'd0,  9'h000, 4'h0};
  logic [46:0] cx    = {9'h1aa, 6'd20, 6'd21, 1'b0, 6'd22, 6'd23, 9'h055, 4'h8};
  logic [46:0] ctx [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [46:0] out_w();
    return {bus.control_in_p, bus.control_put_in_p, bus.control_put_out_p,
            bus.write_back_p, bus.control_pred, bus.control_send_p,
            bus.control_out_p, bus.control_pe2fu_p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [46:0] w, input logic b, input logic d);
    chk({tag, ".word"}, 64'(out_w()), 64'(w));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(b));
    chk({tag, ".done"}, 64'(bus.done), 64'(d));
  endtask

  task automatic do_start(input logic [3:0] lp, input logic [7:0] lc);
    bus.last_pc  = lp;
    bus.loop_cnt = lc;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    // Later changes must not affect the running loop
    bus.last_pc  = 4'd0;
    bus.loop_cnt = 8'd7;
  endtask

  initial begin
    ctx[0] = c0; ctx[1] = c1; ctx[2] = c2; ctx[3] = c3;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.stall = 1'b0;
    bus.last_pc = '0; bus.loop_cnt = '0;

    // Reset and idle outputs
    step();
    step();
    chk_out("reset", nop_w, 1'b0, 1'b0);
    chk("reset.ctx_pc", 64'(bus.ctx_pc), 64'd0);
    chk("reset.conflict", 64'(bus.conflict_err), 64'd0);
    rst = 1'b0;

    // Load contexts 0..3
    for (int i = 0; i < 4; i++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'(i);
      bus.cfg_data = ctx[i];
      step();
    end
    bus.cfg_we = 1'b0;
    step();
    chk_out("idle", nop_w, 1'b0, 1'b0);

    // Basic loop: 3 contexts x 2 iterations
    do_start(4'd2, 8'd2);
    for (int k = 0; k < 6; k++) begin
      chk_out($sformatf("loop%0d", k), ctx[k % 3], 1'b1, 1'b0);
      chk($sformatf("loop%0d.pc", k), 64'(bus.ctx_pc), 64'(k % 3));
      step();
    end
    chk_out("loop.done", nop_w, 1'b0, 1'b1);
    step();
    chk_out("loop.after", nop_w, 1'b0, 1'b0);
    step();

    // Stall: ctx 1 held back for 3 cycles
    do_start(4'd2, 8'd1);
    chk_out("stall.c0", c0, 1'b1, 1'b0);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stall.nop%0d", k), nop_w, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    chk_out("stall.c1", c1, 1'b1, 1'b0);
    step();
    chk_out("stall.c2", c2, 1'b1, 1'b0);
    step();
    chk_out("stall.done", nop_w, 1'b0, 1'b1);
    step();
    step();

    // Abort while ctx 1 of iteration 0 is issued
    do_start(4'd2, 8'd2);
    step();
    chk_out("abort.c1", c1, 1'b1, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_out("abort.nop", nop_w, 1'b0, 1'b0);
    step();
    chk_out("abort.nodone", nop_w, 1'b0, 1'b0);

    // Write to ctx 0 while running is ignored
    do_start(4'd0, 8'd3);
    chk_out("wr.c0a", c0, 1'b1, 1'b0);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = cx;
    step();
    bus.cfg_we = 1'b0;
    chk_out("wr.c0b", c0, 1'b1, 1'b0);
    step();
    chk_out("wr.c0c", c0, 1'b1, 1'b0);
    step();
    chk_out("wr.done", nop_w, 1'b0, 1'b1);
    step();

    // loop_cnt=0 runs once; ctx 0 still original
    do_start(4'd0, 8'd0);
    chk_out("lc0.c0", c0, 1'b1, 1'b0);
    step();
    chk_out("lc0.done", nop_w, 1'b0, 1'b1);
    step();

    // Conflict: ctx 3 has wb=1, put_in=put_out=5
    do_start(4'd3, 8'd1);
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("cf%0d", k), ctx[k], 1'b1, 1'b0);
      chk($sformatf("cf%0d.flag", k), 64'(bus.conflict_err), 64'd0);
      step();
    end
    chk_out("cf.done", nop_w, 1'b0, 1'b1);
    chk("cf.set", 64'(bus.conflict_err), 64'(CHK_EN));
    step();
    step();
    chk("cf.sticky", 64'(bus.conflict_err), 64'(CHK_EN));
    do_start(4'd0, 8'd1);
    chk("cf.clear", 64'(bus.conflict_err), 64'd0);
    step();
    step();

    // RST together with start: reset wins
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk_out("rststart", nop_w, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_ctx_seq.md
# pred_ctx_seq

Predicate-path context sequencer for one PE. It holds a small context memory of predicate-control words and steps through it on start. Each cycle it drives every control input of the PE's predicate register file / predicate crossbar: input select, put-in/put-out addresses, write-back, FU read address, send address, output select and PE-to-FU select. It sits between the array configuration loader and the predicate register file.

## Interface
- CTX_DEPTH, 16: number of context words; power of two.
- CTX_AW, 4: context address width, log2(CTX_DEPTH).
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  CTX_AW  context write address.
- cfg_data  in  47  context word {in_sel[8:0], put_in[5:0], put_out[5:0], wb, pred_rd[5:0], send[5:0], out_sel[8:0], pe2fu[3:0]}, MSB first.
- start  in  1  begin execution; sampled in IDLE only.
- abort  in  1  return to IDLE immediately.
- stall  in  1  freeze PC and iteration count; emit NOP.
- last_pc  in  CTX_AW  last context index of the loop body.
- loop_cnt  in  8  iteration count; 0 is treated as 1.
- control_in_p  out  9;  control_put_in_p  out  6;  control_put_out_p  out  6;  write_back_p  out  1;  control_pred  out  6;  control_send_p  out  6;  control_out_p  out  9;  control_pe2fu_p  out  4.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at loop completion.
- ctx_pc  out  CTX_AW  index of the context currently on the outputs.
- conflict_err  out  1  sticky write-conflict flag.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE after the final context of the final iteration.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on abort or RST.
- Context memory:
  - Written only in IDLE when cfg_we=1.
  - cfg_we in RUN or DONE is ignored and the memory is unchanged.
  - Context memory is not cleared by RST.
- NOP word:
  - in_sel=0, put_in=63, put_out=63, wb=0, pred_rd=0, send=0, out_sel=0, pe2fu=4'b1111.
  - Register 63 is a reserved sink, because the register file writes put_in on every cycle.
  - Outputs carry NOP in IDLE, in DONE, during stall, and after reset.
- PC and iteration sequencing:
  - At the end of each context, if pc==last_pc then pc←0 and iter←iter+1; otherwise pc←pc+1.
  - Completion occurs when pc==last_pc and iter==max(loop_cnt,1)−1.
- last_pc and loop_cnt are latched on start. Later changes do not affect the running loop.
- stall: PC and iteration count hold, outputs are NOP, and the stalled context is reissued when stall drops.
- abort takes priority over stall; stall takes priority over the PC advance.
- Conflict check: flag when the issued word has wb=1 and put_out==put_in and put_in!=63. The word is still issued unmodified; the put_out write wins in the register file.

## Timing
- All outputs are registered. They change at posedge and are consumed by the register file on the following negedge.
- Latency: start sampled at posedge N → context 0 is on the outputs during cycle N+1 and busy=1 from N+1.
- One context is issued per unstalled cycle. A body of L=last_pc+1 contexts with K iterations occupies exactly L·K RUN cycles.
- The cycle after the final context: outputs are NOP, done=1, busy=0. The cycle after that the FSM is in IDLE.
- abort at posedge M → NOP and busy=0 from cycle M+1. No done pulse.
- RST: outputs NOP, busy=0, done=0, ctx_pc=0, conflict_err=0, state=IDLE.
- start with RST in the same cycle: RST wins.
- start in RUN is ignored.

## Configuration
- PRED_CTX_WBCHK_EN defined: conflict checker compiled in; conflict_err is set on the flagged cycle (visible the next cycle) and cleared only by RST or start.
- PRED_CTX_WBCHK_EN undefined: checker logic absent; conflict_err tied to 0.

## Structure
- Package pred_ctx_pkg holds:
  - field widths and bit offsets for the 47-bit context word
  - NOP field constants, including the sink address 63
  - FSM state encoding
- Sub-module pred_ctx_mem: CTX_DEPTH×47 register array with synchronous write and asynchronous read by PC.
- Sequencing, FSM and output registers live in pred_ctx_seq.

## Test plan
- Reset and idle outputs: assert RST for 2 cycles. All outputs show NOP (put_in=63, pe2fu=4'b1111, wb=0, out_sel=0), busy=0 and done=0.
- Basic loop: load 3 distinct contexts, last_pc=2, loop_cnt=2, pulse start. The bench sees ctx 0,1,2,0,1,2 on 6 consecutive cycles, then done=1 for 1 cycle, then NOP.
- Stall: raise stall for 3 cycles while ctx 1 is issued. The bench sees 3 NOP cycles, then ctx 1 reissued, and 3 extra cycles added to the total.
- Abort: abort while ctx 1 of iteration 0 is issued. NOP and busy=0 the next cycle, with no done pulse.
- Write while running: cfg_we to addr 0 with new data during RUN. A following run still issues the original ctx 0.
- Conflict check (PRED_CTX_WBCHK_EN defined): a context with wb=1 and put_in=put_out=5 sets conflict_err; it stays set until the next start clears it. With the macro undefined, conflict_err stays 0.
